ami_cmd_arb: RTL and testbench
==============================

AMI_CMD_ARB -- requirements
Module: ami_cmd_arb

Interface
REQ-001 Parameter NREQ, default 4, is the number of DMA command requesters (2..8).
REQ-002 Parameter CFG_W, default 32, is the start-address and length width in bits.
REQ-003 Parameter IDXW, default $clog2(NREQ), is the requester index width.
REQ-004 Port clk, input, 1, is the single clock: one clock; reset is asynchronous and active-low.
REQ-005 Port reset_n, input, 1, is the asynchronous active-low reset.
REQ-006 Port req_valid, input, NREQ, is the per-requester command valid.
REQ-007 Port req_ready, output, NREQ, is the per-requester command accept.
REQ-008 Port req_dir, input, NREQ, is the per-requester direction (0 = DMA write, 1 = DMA read).
REQ-009 Port req_sa, input, NREQ x CFG_W, is the per-requester start address.
REQ-010 Port req_len, input, NREQ x CFG_W, is the per-requester byte length.
REQ-011 Ports cfg_dmaw_valid (output, 1), cfg_dmaw_ready (input, 1), cfg_dmaw_sa (output, CFG_W) and cfg_dmaw_len (output, CFG_W) form the AMI DMA-write command port.
REQ-012 Ports cfg_dmar_valid (output, 1), cfg_dmar_ready (input, 1), cfg_dmar_sa (output, CFG_W) and cfg_dmar_len (output, CFG_W) form the AMI DMA-read command port.
REQ-013 Ports err_zlen (output, 1) and err_idx (output, IDXW) report a dropped zero-length command with its requester index.

Function
REQ-014 Write and read are two independent channels, each with FSM states IDLE and ISSUE.
REQ-015 A channel's candidate set is every requester i with req_valid[i]=1 and req_dir[i] equal to the channel's direction.
REQ-016 In IDLE with a non-empty candidate set, the channel grants one requester by round-robin, searching upward from its pointer with wrap.
REQ-017 On a grant, req_ready[i] SHALL be 1 in the same cycle (combinational from req_valid), and req_ready SHALL be 0 for every non-granted requester.
REQ-018 On a grant with req_len!=0, the channel registers sa/len into its cfg outputs, goes to ISSUE, and asserts cfg_*_valid on the next cycle.
REQ-019 On a grant with req_len==0, the channel drops the command, stays in IDLE, and pulses err_zlen=1 with err_idx=i for one cycle on the next cycle.
REQ-020 If both channels drop a zero-length command in the same cycle, the write channel reports first and the read error is reported one cycle later (one-entry holding register).
REQ-021 After any grant to i, the channel pointer becomes (i+1) mod NREQ; the pointer is unchanged when there is no grant.
REQ-022 In ISSUE, cfg_*_valid, sa and len SHALL stay stable until cfg_*_ready=1; on that handshake the channel returns to IDLE.
REQ-023 The handshake cycle issues no grant, so the minimum spacing is 2 cycles per command per channel.
REQ-024 In ISSUE the channel ignores all requests and keeps req_ready=0 for its direction.
REQ-025 The two channels may each grant a different requester in the same cycle.
REQ-026 cfg_*_ready asserted while cfg_*_valid=0 SHALL have no effect.

Reset
REQ-027 On reset_n=0, asynchronously: both FSMs go to IDLE and both pointers to 0.
REQ-028 On reset_n=0, asynchronously: all outputs go to 0 (req_ready, cfg_*_valid/sa/len, err_zlen, err_idx).
REQ-029 A reset during ISSUE discards the pending command; it is not re-issued after reset.

Structure
REQ-030 IDXW computation and the direction encoding constants (DIR_WR=0, DIR_RD=1) SHALL reside in the shared AMI package.
REQ-031 The round-robin picker SHALL be one sub-module, ami_rr_pick, instantiated once per channel.
REQ-032 ami_rr_pick has inputs request vector and pointer, and outputs grant-valid, grant index and one-hot grant.

Verification
REQ-033 Scenario, single write: req0 valid, dir=0, sa=0x1000, len=256; cfg_dmaw_ready=1.
-> req_ready[0] is 1 in cycle 0; cfg_dmaw_valid=1 with sa=0x1000 and len=256 in cycle 1; back to IDLE in cycle 2.
REQ-034 Scenario, fairness: all 4 requesters write-valid continuously, ready always 1.
-> grant order is 0,1,2,3,0 with one grant every 2 cycles.
REQ-035 Scenario, backpressure: cfg_dmaw_ready=0 for 5 cycles after valid.
-> cfg_dmaw_valid/sa/len are held stable all 5 cycles; no req_ready for write-direction requesters meanwhile.
REQ-036 Scenario, zero length: req2 write with len=0, and req3 read with len=0, in the same cycle.
-> err_zlen with err_idx=2 in the next cycle, err_idx=3 one cycle later; neither cfg valid asserts.
REQ-037 Scenario, concurrency: req1 write and req2 read in the same cycle.
-> both req_ready bits are 1 in the same cycle; cfg_dmaw_valid and cfg_dmar_valid assert together the next cycle.
REQ-038 Scenario, reset mid-ISSUE: reset_n=0 while cfg_dmar_valid=1.
-> cfg_dmar_valid is 0 immediately (asynchronously); after release the pointers are 0 and the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/ami_cmd_arb_pkg.sv
// ----------------------------------------------------------------------------
// ami_cmd_arb_pkg
// Shared AMI definitions: DMA direction encoding, channel FSM states and the
// requester-index width helper used by the command arbiter and its picker.
// ----------------------------------------------------------------------------
package ami_cmd_arb_pkg;

    // Direction encoding carried on req_dir
    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    // Per-channel command FSM
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } ch_state_e;

    // Requester index width; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ami_rr_pick.sv
// ----------------------------------------------------------------------------
// ami_rr_pick
// Round-robin picker: grants the first requesting index found searching
// upward from i_ptr, wrapping past NREQ-1 back to 0.
// Ports:
//   i_req       request vector
//   i_ptr       index to start the search from
//   o_gnt_valid at least one request present
//   o_gnt_idx   granted index (0 when no request)
//   o_gnt_oh    one-hot grant (all zero when no request)
// ----------------------------------------------------------------------------
module ami_rr_pick
    import ami_cmd_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_gnt_valid,
    output logic [IDXW-1:0] o_gnt_idx,
    output logic [NREQ-1:0] o_gnt_oh
);

    logic [NREQ-1:0] w_upper;
    logic [NREQ-1:0] w_sel;

    // Prefer requests at or above the pointer; otherwise wrap to the whole
    // vector. The lowest set bit of the chosen set is then the grant.
    always_comb begin
        w_upper = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_upper[i] = i_req[i] & (IDXW'(i) >= i_ptr);
        end
        w_sel       = (|w_upper) ? w_upper : i_req;
        // Two's-complement trick isolates the lowest set bit
        o_gnt_oh    = w_sel & (~w_sel + {{(NREQ-1){1'b0}}, 1'b1});
        o_gnt_valid = |i_req;
        o_gnt_idx   = {IDXW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            o_gnt_idx = o_gnt_idx | (o_gnt_oh[i] ? IDXW'(i) : {IDXW{1'b0}});
        end
    end

endmodule

// File: rtl/ami_cmd_arb.sv
// ----------------------------------------------------------------------------
// ami_cmd_arb
// Arbitrates NREQ DMA command requesters onto the AMI DMA-write and DMA-read
// command ports. Each direction is an independent IDLE/ISSUE channel with its
// own round-robin pointer. Zero-length commands are dropped and reported.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   req_valid/req_ready/req_dir      per-requester command handshake + direction
//   req_sa/req_len                   per-requester start address / length (packed)
//   cfg_dmaw_*                       DMA-write command port (valid/ready/sa/len)
//   cfg_dmar_*                       DMA-read command port (valid/ready/sa/len)
//   err_zlen/err_idx                 one-cycle report of a dropped zero-length cmd
// ----------------------------------------------------------------------------
module ami_cmd_arb
    import ami_cmd_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CFG_W = 32,
    parameter int IDXW  = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_dir,
    input  logic [NREQ*CFG_W-1:0] req_sa,
    input  logic [NREQ*CFG_W-1:0] req_len,
    output logic                  cfg_dmaw_valid,
    input  logic                  cfg_dmaw_ready,
    output logic [CFG_W-1:0]      cfg_dmaw_sa,
    output logic [CFG_W-1:0]      cfg_dmaw_len,
    output logic                  cfg_dmar_valid,
    input  logic                  cfg_dmar_ready,
    output logic [CFG_W-1:0]      cfg_dmar_sa,
    output logic [CFG_W-1:0]      cfg_dmar_len,
    output logic                  err_zlen,
    output logic [IDXW-1:0]       err_idx
);

    ch_state_e         r_wr_state, r_rd_state;
    logic [IDXW-1:0]   r_wr_ptr, r_rd_ptr;
    logic              r_hold_v;
    logic [IDXW-1:0]   r_hold_idx;

    logic [NREQ-1:0]   w_wr_cand, w_rd_cand;
    logic              w_wr_gv, w_rd_gv;
    logic [IDXW-1:0]   w_wr_idx, w_rd_idx;
    logic [NREQ-1:0]   w_wr_oh, w_rd_oh;
    logic              w_wr_grant, w_rd_grant;
    logic [CFG_W-1:0]  w_wr_sa, w_wr_len, w_rd_sa, w_rd_len;
    logic              w_wr_zdrop, w_rd_zdrop;

    // Split valid requesters into the write and read candidate sets
    always_comb begin
        w_wr_cand = {NREQ{1'b0}};
        w_rd_cand = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_wr_cand[i] = req_valid[i] & (req_dir[i] == DIR_WR);
            w_rd_cand[i] = req_valid[i] & (req_dir[i] == DIR_RD);
        end
    end

    ami_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_wr_pick (
        .i_req       (w_wr_cand),
        .i_ptr       (r_wr_ptr),
        .o_gnt_valid (w_wr_gv),
        .o_gnt_idx   (w_wr_idx),
        .o_gnt_oh    (w_wr_oh)
    );

    ami_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_rd_pick (
        .i_req       (w_rd_cand),
        .i_ptr       (r_rd_ptr),
        .o_gnt_valid (w_rd_gv),
        .o_gnt_idx   (w_rd_idx),
        .o_gnt_oh    (w_rd_oh)
    );

    assign w_wr_grant = (r_wr_state == ST_IDLE) & w_wr_gv;
    assign w_rd_grant = (r_rd_state == ST_IDLE) & w_rd_gv;

    // One-hot select of the granted requester's address and length
    always_comb begin
        w_wr_sa  = {CFG_W{1'b0}};
        w_wr_len = {CFG_W{1'b0}};
        w_rd_sa  = {CFG_W{1'b0}};
        w_rd_len = {CFG_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_wr_sa  = w_wr_sa  | (req_sa [i*CFG_W +: CFG_W] & {CFG_W{w_wr_oh[i]}});
            w_wr_len = w_wr_len | (req_len[i*CFG_W +: CFG_W] & {CFG_W{w_wr_oh[i]}});
            w_rd_sa  = w_rd_sa  | (req_sa [i*CFG_W +: CFG_W] & {CFG_W{w_rd_oh[i]}});
            w_rd_len = w_rd_len | (req_len[i*CFG_W +: CFG_W] & {CFG_W{w_rd_oh[i]}});
        end
    end

    assign w_wr_zdrop = w_wr_grant & (w_wr_len == {CFG_W{1'b0}});
    assign w_rd_zdrop = w_rd_grant & (w_rd_len == {CFG_W{1'b0}});

    // Accept is combinational from req_valid so the requester sees it in the
    // grant cycle; forced low while reset is asserted.
    always_comb begin
        if (!reset_n) begin
            req_ready = {NREQ{1'b0}};
        end else begin
            req_ready = (w_wr_grant ? w_wr_oh : {NREQ{1'b0}})
                      | (w_rd_grant ? w_rd_oh : {NREQ{1'b0}});
        end
    end

    // Write channel FSM: grant/drop in IDLE, hold the command in ISSUE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_state     <= ST_IDLE;
            r_wr_ptr       <= {IDXW{1'b0}};
            cfg_dmaw_valid <= 1'b0;
            cfg_dmaw_sa    <= {CFG_W{1'b0}};
            cfg_dmaw_len   <= {CFG_W{1'b0}};
        end else begin
            case (r_wr_state)
                ST_IDLE: begin
                    if (w_wr_gv) begin
                        r_wr_ptr <= (w_wr_idx == IDXW'(NREQ-1)) ? {IDXW{1'b0}}
                                                                : w_wr_idx + IDXW'(1'b1);
                        if (!w_wr_zdrop) begin
                            cfg_dmaw_valid <= 1'b1;
                            cfg_dmaw_sa    <= w_wr_sa;
                            cfg_dmaw_len   <= w_wr_len;
                            r_wr_state     <= ST_ISSUE;
                        end else begin
                            r_wr_state     <= ST_IDLE;
                        end
                    end else begin
                        r_wr_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cfg_dmaw_ready) begin
                        cfg_dmaw_valid <= 1'b0;
                        r_wr_state     <= ST_IDLE;
                    end else begin
                        r_wr_state     <= ST_ISSUE;
                    end
                end
                default: begin
                    cfg_dmaw_valid <= 1'b0;
                    r_wr_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: same behaviour as the write channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_state     <= ST_IDLE;
            r_rd_ptr       <= {IDXW{1'b0}};
            cfg_dmar_valid <= 1'b0;
            cfg_dmar_sa    <= {CFG_W{1'b0}};
            cfg_dmar_len   <= {CFG_W{1'b0}};
        end else begin
            case (r_rd_state)
                ST_IDLE: begin
                    if (w_rd_gv) begin
                        r_rd_ptr <= (w_rd_idx == IDXW'(NREQ-1)) ? {IDXW{1'b0}}
                                                                : w_rd_idx + IDXW'(1'b1);
                        if (!w_rd_zdrop) begin
                            cfg_dmar_valid <= 1'b1;
                            cfg_dmar_sa    <= w_rd_sa;
                            cfg_dmar_len   <= w_rd_len;
                            r_rd_state     <= ST_ISSUE;
                        end else begin
                            r_rd_state     <= ST_IDLE;
                        end
                    end else begin
                        r_rd_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (cfg_dmar_ready) begin
                        cfg_dmar_valid <= 1'b0;
                        r_rd_state     <= ST_IDLE;
                    end else begin
                        r_rd_state     <= ST_ISSUE;
                    end
                end
                default: begin
                    cfg_dmar_valid <= 1'b0;
                    r_rd_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-length reporting, oldest first: held report, then write, then read.
    // Only one report can be held; if the holding slot is busy while both
    // channels drop in the same cycle, the newest (read) report is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_zlen   <= 1'b0;
            err_idx    <= {IDXW{1'b0}};
            r_hold_v   <= 1'b0;
            r_hold_idx <= {IDXW{1'b0}};
        end else if (r_hold_v) begin
            err_zlen   <= 1'b1;
            err_idx    <= r_hold_idx;
            r_hold_v   <= w_wr_zdrop | w_rd_zdrop;
            r_hold_idx <= w_wr_zdrop ? w_wr_idx : w_rd_idx;
        end else if (w_wr_zdrop) begin
            err_zlen   <= 1'b1;
            err_idx    <= w_wr_idx;
            r_hold_v   <= w_rd_zdrop;
            r_hold_idx <= w_rd_idx;
        end else if (w_rd_zdrop) begin
            err_zlen   <= 1'b1;
            err_idx    <= w_rd_idx;
            r_hold_v   <= 1'b0;
            r_hold_idx <= {IDXW{1'b0}};
        end else begin
            err_zlen   <= 1'b0;
            err_idx    <= {IDXW{1'b0}};
            r_hold_v   <= 1'b0;
            r_hold_idx <= {IDXW{1'b0}};
        end
    end

endmodule

// File: tb/tb_ami_cmd_arb.sv
// ----------------------------------------------------------------------------
// tb_ami_cmd_arb
// Directed scenarios plus randomized traffic for ami_cmd_arb, checked every
// cycle against a transaction-level model of the two arbitration channels.
// ----------------------------------------------------------------------------
module tb_ami_cmd_arb;

    localparam int NREQ  = 4;
    localparam int CFG_W = 32;
    localparam int IDXW  = 2;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*CFG_W-1:0] req_sa;
    logic [NREQ*CFG_W-1:0] req_len;
    logic                  cfg_dmaw_valid, cfg_dmaw_ready;
    logic [CFG_W-1:0]      cfg_dmaw_sa, cfg_dmaw_len;
    logic                  cfg_dmar_valid, cfg_dmar_ready;
    logic [CFG_W-1:0]      cfg_dmar_sa, cfg_dmar_len;
    logic                  err_zlen;
    logic [IDXW-1:0]       err_idx;

    ami_cmd_arb #(.NREQ(NREQ), .CFG_W(CFG_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dir        (req_dir),
        .req_sa         (req_sa),
        .req_len        (req_len),
        .cfg_dmaw_valid (cfg_dmaw_valid),
        .cfg_dmaw_ready (cfg_dmaw_ready),
        .cfg_dmaw_sa    (cfg_dmaw_sa),
        .cfg_dmaw_len   (cfg_dmaw_len),
        .cfg_dmar_valid (cfg_dmar_valid),
        .cfg_dmar_ready (cfg_dmar_ready),
        .cfg_dmar_sa    (cfg_dmar_sa),
        .cfg_dmar_len   (cfg_dmar_len),
        .err_zlen       (err_zlen),
        .err_idx        (err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: channel 0 = write, channel 1 = read
    bit          m_busy [2];
    int          m_ptr  [2];
    logic [31:0] m_sa   [2];
    logic [31:0] m_len  [2];
    bit          m_err_v;
    int          m_err_idx;
    int          m_hold [$];
    int          cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0;
            m_ptr[d]  = 0;
            m_sa[d]   = 32'h0;
            m_len[d]  = 32'h0;
        end
        m_err_v   = 1'b0;
        m_err_idx = 0;
        m_hold.delete();
    endtask

    task automatic clear_inputs();
        req_valid      = '0;
        req_dir        = '0;
        req_sa         = '0;
        req_len        = '0;
        cfg_dmaw_ready = 1'b0;
        cfg_dmar_ready = 1'b0;
    endtask

    task automatic set_req(input int i, input bit v, input bit d,
                           input logic [31:0] sa, input logic [31:0] len);
        req_valid[i]              = v;
        req_dir[i]                = d;
        req_sa[i*CFG_W +: CFG_W]  = sa;
        req_len[i*CFG_W +: CFG_W] = len;
    endtask

    // Called at a falling edge with inputs applied: compare every output with
    // the model, advance the model by one clock, then move to the next falling edge.
    task automatic step();
        bit          f [2];
        int          g [2];
        logic [NREQ-1:0] exp_rdy;
        int          q [$];
        logic [31:0] glen;
        bit          rdy;
        #1;
        exp_rdy = '0;
        for (int d = 0; d < 2; d++) begin
            f[d] = 1'b0;
            g[d] = 0;
            if (!m_busy[d]) begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr[d] + k) % NREQ;
                    if (!f[d] && req_valid[j] && (int'(req_dir[j]) == d)) begin
                        f[d] = 1'b1;
                        g[d] = j;
                    end
                end
            end
            if (f[d]) exp_rdy[g[d]] = 1'b1;
        end
        chk("req_ready", req_ready, exp_rdy);
        chk("dmaw_valid", cfg_dmaw_valid, m_busy[0]);
        if (m_busy[0]) begin
            chk("dmaw_sa", cfg_dmaw_sa, m_sa[0]);
            chk("dmaw_len", cfg_dmaw_len, m_len[0]);
        end
        chk("dmar_valid", cfg_dmar_valid, m_busy[1]);
        if (m_busy[1]) begin
            chk("dmar_sa", cfg_dmar_sa, m_sa[1]);
            chk("dmar_len", cfg_dmar_len, m_len[1]);
        end
        chk("err_zlen", err_zlen, m_err_v);
        if (m_err_v) chk("err_idx", err_idx, m_err_idx);

        // Advance: reports queue oldest-first, one goes out, one may wait
        q = m_hold;
        for (int d = 0; d < 2; d++) begin
            rdy = (d == 0) ? cfg_dmaw_ready : cfg_dmar_ready;
            if (m_busy[d]) begin
                if (rdy) m_busy[d] = 1'b0;
            end else if (f[d]) begin
                m_ptr[d] = (g[d] + 1) % NREQ;
                glen = req_len[g[d]*CFG_W +: CFG_W];
                if (glen != 32'h0) begin
                    m_busy[d] = 1'b1;
                    m_sa[d]   = req_sa[g[d]*CFG_W +: CFG_W];
                    m_len[d]  = glen;
                end else begin
                    q.push_back(g[d]);
                end
            end
        end
        m_err_v = (q.size() > 0);
        m_err_idx = m_err_v ? q[0] : 0;
        m_hold.delete();
        if (q.size() > 1) m_hold.push_back(q[1]);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_dmaw_valid", cfg_dmaw_valid, 0);
        chk("rst_dmar_valid", cfg_dmar_valid, 0);
        chk("rst_dmaw_sa", cfg_dmaw_sa, 0);
        chk("rst_dmar_len", cfg_dmar_len, 0);
        chk("rst_err_zlen", err_zlen, 0);
        chk("rst_err_idx", err_idx, 0);
        model_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b1;
    endtask

    int gq [$];
    int gc [$];
    int fair_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write
        set_req(0, 1'b1, 1'b0, 32'h1000, 32'd256);
        cfg_dmaw_ready = 1'b1;
        #1 chk("single_ready", req_ready, 4'b0001);
        step();
        clear_inputs();
        cfg_dmaw_ready = 1'b1;
        #1;
        chk("single_valid", cfg_dmaw_valid, 1);
        chk("single_sa", cfg_dmaw_sa, 32'h1000);
        chk("single_len", cfg_dmaw_len, 32'd256);
        step();
        #1 chk("single_idle", cfg_dmaw_valid, 0);
        step();

        // Fairness: everyone writes continuously
        do_reset();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 32'h100 * i, 32'h10 + i);
            cfg_dmaw_ready = 1'b1;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    gq.push_back(i);
                    gc.push_back(c);
                end
            end
            step();
        end
        chk("fair_count", gq.size(), 5);
        for (int k = 0; k < 5 && k < gq.size(); k++) begin
            chk("fair_order", gq[k], fair_exp[k]);
            if (k > 0) chk("fair_spacing", gc[k] - gc[k-1], 2);
        end

        // Backpressure
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'hAAAA0000, 32'h40);
        step();
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h5, 32'h6);
        set_req(2, 1'b1, 1'b0, 32'h7, 32'h8);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", cfg_dmaw_valid, 1);
            chk("bp_sa", cfg_dmaw_sa, 32'hAAAA0000);
            chk("bp_len", cfg_dmaw_len, 32'h40);
            chk("bp_no_ready", req_ready, 4'b0000);
            step();
        end
        clear_inputs();
        cfg_dmaw_ready = 1'b1;
        step();
        #1 chk("bp_release", cfg_dmaw_valid, 0);

        // Zero length on both channels in one cycle
        do_reset();
        set_req(2, 1'b1, 1'b0, 32'h11, 32'h0);
        set_req(3, 1'b1, 1'b1, 32'h22, 32'h0);
        #1 chk("zl_ready", req_ready, 4'b1100);
        step();
        clear_inputs();
        #1;
        chk("zl_err1", err_zlen, 1);
        chk("zl_idx1", err_idx, 2);
        chk("zl_nowv", cfg_dmaw_valid, 0);
        step();
        #1;
        chk("zl_err2", err_zlen, 1);
        chk("zl_idx2", err_idx, 3);
        chk("zl_nowr", cfg_dmar_valid, 0);
        step();
        #1 chk("zl_err_end", err_zlen, 0);

        // Concurrency
        do_reset();
        set_req(1, 1'b1, 1'b0, 32'h300, 32'h30);
        set_req(2, 1'b1, 1'b1, 32'h400, 32'h40);
        #1 chk("conc_ready", req_ready, 4'b0110);
        step();
        clear_inputs();
        #1;
        chk("conc_wv", cfg_dmaw_valid, 1);
        chk("conc_rv", cfg_dmar_valid, 1);
        step();

        // Reset while a read is issuing
        do_reset();
        set_req(2, 1'b1, 1'b1, 32'h900, 32'h8);
        step();
        clear_inputs();
        #1 chk("rmid_pre", cfg_dmar_valid, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rmid_async_valid", cfg_dmar_valid, 0);
        chk("rmid_async_ready", req_ready, 0);
        do_reset();
        set_req(1, 1'b1, 1'b1, 32'hA0, 32'h1);
        set_req(3, 1'b1, 1'b1, 32'hB0, 32'h2);
        #1 chk("rmid_lowest", req_ready, 4'b0010);
        step();
        clear_inputs();
        step();
        #1 chk("rmid_no_reissue_len", cfg_dmar_len, 32'h1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom(),
                        ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom());
            end
            cfg_dmaw_ready = 1'($urandom_range(0, 1));
            cfg_dmar_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
